// File: rtl/alu_serial_ctrl_if.sv
// Handshake and slice bus for the bit-serial ALU sequencer.
interface alu_serial_ctrl_if #(
  parameter int unsigned N = 8
);
  // Request channel
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_a;
  logic [N-1:0] req_b;
  logic [1:0]   req_op;
  logic         req_cin;
  // 1-bit slice connection
  logic         alu_a;
  logic         alu_b;
  logic         alu_cin;
  logic [1:0]   alu_s_op;
  logic         alu_z;
  logic         alu_cout;
  // Response channel
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_z;
  logic         rsp_cout;

  // Sequencer side
  modport slave (
    input  req_valid, req_a, req_b, req_op, req_cin,
    input  alu_z, alu_cout, rsp_ready,
    output req_ready, alu_a, alu_b, alu_cin, alu_s_op,
    output rsp_valid, rsp_z, rsp_cout
  );

  // Requester / slice / consumer side
  modport master (
    output req_valid, req_a, req_b, req_op, req_cin,
    output alu_z, alu_cout, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_cin, alu_s_op,
    input  rsp_valid, rsp_z, rsp_cout
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer: drives one 1-bit ALU slice LSB first to build an
// N-bit result, chaining the slice carry-out back into its carry-in.
module alu_serial_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_serial_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_a_sh;
  logic [N-1:0]     r_b_sh;
  logic [N-1:0]     r_z_sh;
  logic             r_carry;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_ready;
  logic             r_rsp_valid;

  logic             w_run;

  // Sequencer state, operand shifters and handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_z_sh      <= '0;
      r_carry     <= 1'b0;
      r_op        <= 2'b00;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_a_sh      <= bus.req_a;
            r_b_sh      <= bus.req_b;
            r_op        <= bus.req_op;
            r_carry     <= bus.req_cin;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          r_z_sh  <= {bus.alu_z, r_z_sh[N-1:1]};
          r_carry <= bus.alu_cout;
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(N - 1)) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Slice inputs are gated copies of flops so they read 0 outside RUN
  assign w_run        = (r_state == S_RUN);
  assign bus.alu_a    = w_run & r_a_sh[0];
  assign bus.alu_b    = w_run & r_b_sh[0];
  assign bus.alu_cin  = w_run & r_carry;
  assign bus.alu_s_op = w_run ? r_op : 2'b00;

  // Handshake and result come straight from flops; no path from alu_z/alu_cout
  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_z     = r_z_sh;
  assign bus.rsp_cout  = r_carry;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl with a behavioural full-adder slice.
module tb_alu_serial_ctrl;

  localparam int unsigned N = 4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  alu_serial_ctrl_if #(.N(N)) bus ();

  alu_serial_ctrl #(.N(N)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural 1-bit slice: full adder regardless of op
  assign bus.alu_z    = bus.alu_a ^ bus.alu_b ^ bus.alu_cin;
  assign bus.alu_cout = (bus.alu_a & bus.alu_b) | (bus.alu_a & bus.alu_cin) |
                        (bus.alu_b & bus.alu_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_alu_a"},     32'(bus.alu_a),     32'd0);
    chk({tag, "_alu_b"},     32'(bus.alu_b),     32'd0);
    chk({tag, "_alu_cin"},   32'(bus.alu_cin),   32'd0);
    chk({tag, "_alu_s_op"},  32'(bus.alu_s_op),  32'd0);
  endtask

  // One full transaction: accept, N RUN cycles, optional backpressure, drain
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op, input logic cin,
                        input logic [3:0] exp_z, input logic exp_cout,
                        input int hold, input bit poke);
    logic c;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.req_cin   = cin;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    c = cin;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_a%0d", tag, i),    32'(bus.alu_a),     32'(a[i]));
      chk($sformatf("%s_b%0d", tag, i),    32'(bus.alu_b),     32'(b[i]));
      chk($sformatf("%s_cin%0d", tag, i),  32'(bus.alu_cin),   32'(c));
      chk($sformatf("%s_op%0d", tag, i),   32'(bus.alu_s_op),  32'(op));
      chk($sformatf("%s_rdy%0d", tag, i),  32'(bus.req_ready), 32'd0);
      chk($sformatf("%s_vld%0d", tag, i),  32'(bus.rsp_valid), 32'd0);
      c = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      if (poke && i == 1) begin
        bus.req_valid = 1'b1;
        bus.req_a     = ~a;
        bus.req_b     = 4'hF;
        bus.req_op    = 2'b01;
        bus.req_cin   = ~cin;
      end
      tick();
      bus.req_valid = 1'b0;
    end
    chk({tag, "_vld"},   32'(bus.rsp_valid), 32'd1);
    chk({tag, "_z"},     32'(bus.rsp_z),     32'(exp_z));
    chk({tag, "_cout"},  32'(bus.rsp_cout),  32'(exp_cout));
    chk({tag, "_rdy_d"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_op_d"},  32'(bus.alu_s_op),  32'd0);
    chk({tag, "_a_d"},   32'(bus.alu_a),     32'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk($sformatf("%s_hvld%0d", tag, h),  32'(bus.rsp_valid), 32'd1);
      chk($sformatf("%s_hz%0d", tag, h),    32'(bus.rsp_z),     32'(exp_z));
      chk($sformatf("%s_hcout%0d", tag, h), 32'(bus.rsp_cout),  32'(exp_cout));
      chk($sformatf("%s_hrdy%0d", tag, h),  32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk_idle({tag, "_end"});
  endtask

  initial begin
    n_chk         = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = 2'b00;
    bus.req_cin   = 1'b0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    chk_idle("rst");
    chk("rst_z",    32'(bus.rsp_z),    32'd0);
    chk("rst_cout", 32'(bus.rsp_cout), 32'd0);
    rst = 1'b0;
    tick();

    // 5 + 3 = 8
    run_op("add",  4'b0101, 4'b0011, 2'b00, 1'b0, 4'b1000, 1'b0, 0, 1'b0);
    // 15 + 1 wraps to 0 with carry out
    run_op("wrap", 4'b1111, 4'b0001, 2'b00, 1'b0, 4'b0000, 1'b1, 0, 1'b0);
    // 0 + 0 + cin = 1
    run_op("cin",  4'b0000, 4'b0000, 2'b00, 1'b1, 4'b0001, 1'b0, 0, 1'b0);
    // op 10 passed through; busy request pulse must be ignored; 6 + 4 = 10
    run_op("op",   4'b0110, 4'b0100, 2'b10, 1'b0, 4'b1010, 1'b0, 0, 1'b1);
    // 3 + 6 = 9 held under 5 cycles of backpressure
    run_op("bp",   4'b0011, 4'b0110, 2'b00, 1'b0, 4'b1001, 1'b0, 5, 1'b0);

    // Reset on the 2nd RUN cycle discards the operation
    bus.req_a     = 4'b0101;
    bus.req_b     = 4'b0011;
    bus.req_op    = 2'b11;
    bus.req_cin   = 1'b0;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("mid_op_run", 32'(bus.alu_s_op), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("mid");
    chk("mid_z",    32'(bus.rsp_z),    32'd0);
    chk("mid_cout", 32'(bus.rsp_cout), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("mid_novld%0d", k), 32'(bus.rsp_valid), 32'd0);
    end
    run_op("post", 4'b0101, 4'b0011, 2'b00, 1'b0, 4'b1000, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer that drives a single alu_1bit instance over its a/b/cin/s_op inputs and collects its z/cout outputs, so one 1-bit slice can compute an N-bit operation.
- Accepts one N-bit request through a valid/ready handshake and feeds operand bits LSB first, one per clock, chaining cout back into cin.
- Assembles the N-bit result and returns it through a second valid/ready handshake.
- The block never decodes s_op; it only passes it through, so it works with any ALU op encoding.

Parameters:
- N, 8, operand/result width in bits; legal range N >= 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_a  in  N  operand A.
- req_b  in  N  operand B.
- req_op  in  2  ALU select, passed to alu_s_op.
- req_cin  in  1  carry-in for bit 0.
- alu_a  out  1  current A bit to the slice.
- alu_b  out  1  current B bit to the slice.
- alu_cin  out  1  current carry to the slice.
- alu_s_op  out  2  op select to the slice.
- alu_z  in  1  slice result bit; combinational from the alu_* outputs in the same cycle.
- alu_cout  in  1  slice carry-out; combinational, same cycle.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_z  out  N  assembled result.
- rsp_cout  out  1  carry-out of bit N-1.

Behaviour:
- Reset and ports:
  - Synchronous reset, active-high: clk is the only clock and rst is sampled only on its rising edge.
  - After reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_z=0, rsp_cout=0, all alu_* outputs=0, bit counter=0.
- Registered state: a_sh[N], b_sh[N], z_sh[N], carry, op_reg[2], cnt[$clog2(N)], and a 2-bit state.
- IDLE:
  - req_ready=1 and alu_* outputs are 0.
  - On an edge with req_valid=1, load a_sh=req_a, b_sh=req_b, op_reg=req_op, carry=req_cin, cnt=0, then go to RUN.
- RUN:
  - req_ready=0.
  - Outputs: alu_a=a_sh[0], alu_b=b_sh[0], alu_cin=carry, alu_s_op=op_reg.
  - Each edge: z_sh <= {alu_z, z_sh[N-1:1]}, carry <= alu_cout, a_sh and b_sh shift right by 1, cnt <= cnt+1.
  - On the edge where cnt==N-1, go to DONE.
- DONE:
  - rsp_valid=1, rsp_z=z_sh, rsp_cout=carry; alu_* outputs are 0 and req_ready=0.
  - rsp_z and rsp_cout are held stable while rsp_ready=0.
  - On an edge with rsp_ready=1, go to IDLE and clear rsp_valid.
- Latency and throughput:
  - rsp_valid rises exactly N edges after the request-accept edge.
  - Requests are never overlapped; back-to-back throughput is one result per N+2 cycles when rsp_ready is held high.
- Boundary conditions:
  - req_valid outside IDLE is ignored and no data is captured.
  - Changes on req_a/req_b/req_op after acceptance have no effect.
  - rst=1 in any state returns to IDLE on that edge with all reset values; any in-flight operation is discarded and no response is produced.
  - rst has priority over both handshakes in the same cycle.
  - No combinational path exists from alu_z/alu_cout to any rsp_* or req_ready output.

Test Plan:
(The bench connects a behavioural slice: z=a^b^cin, cout=maj(a,b,cin); N=4.)
- Add: req_a=0101, req_b=0011, req_cin=0 -> alu_a sequence 1,0,1,0 and alu_b sequence 1,1,0,0 over the 4 RUN cycles; rsp_z=1000, rsp_cout=0; rsp_valid exactly 4 edges after accept.
- Wrap: req_a=1111, req_b=0001, req_cin=0 -> rsp_z=0000, rsp_cout=1. Separately, req_a=0000, req_b=0000, req_cin=1 -> rsp_z=0001, rsp_cout=0.
- Op pass-through and busy ignore: req_op=10 -> alu_s_op=10 in every RUN cycle and 00 in IDLE/DONE; a second req_valid pulse during RUN leaves req_ready=0 and does not change the result.
- Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_valid stays 1, rsp_z/rsp_cout stay stable, req_ready stays 0. Raise rsp_ready -> IDLE on the next edge, req_ready=1.
- Reset mid-run: assert rst on the 2nd RUN cycle -> next cycle state is IDLE, rsp_valid=0, req_ready=1, all outputs 0. A fresh request of 0101+0011 then yields 1000.
